// File: rtl/cond_exec_mreg.sv
// Execute-stage condition check against the owned NZCV register, plus the
// E->M pipeline register with flush-over-stall priority and gated side effects.
module cond_exec_mreg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             MemWriteE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       CondE,
    input  logic [3:0]       ALUFlags,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [3:0]       WA3E,
    input  logic             StallM,
    input  logic             FlushM,
    output logic             CondExE,
    output logic             BranchTakenE,
    output logic [3:0]       Flags,
    output logic             PCSrcM,
    output logic             RegWriteM,
    output logic             MemtoRegM,
    output logic             MemWriteM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [3:0]       WA3M
);

    logic [3:0]       r_flags;
    logic             r_pcsrc_m;
    logic             r_regwrite_m;
    logic             r_memtoreg_m;
    logic             r_memwrite_m;
    logic [WIDTH-1:0] r_alu_result_m;
    logic [WIDTH-1:0] r_write_data_m;
    logic [3:0]       r_wa3_m;

    logic w_n, w_z, w_c, w_v;
    logic w_cond_ex;
    logic w_flag_en;

    // Decode always sees the registered flags; there is no bypass from ALUFlags.
    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_cond_ex = 1'b0;
        case (CondE)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_flag_en    = w_cond_ex & ~StallM & ~FlushM;
    assign CondExE      = w_cond_ex;
    assign BranchTakenE = PCSrcE & w_cond_ex;

    // N,Z and C,V halves are written independently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (FlagWriteE[1] && w_flag_en) r_flags[3:2] <= ALUFlags[3:2];
            if (FlagWriteE[0] && w_flag_en) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // A failed condition still loads a valid entry, only its side effects cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pcsrc_m      <= 1'b0;
            r_regwrite_m   <= 1'b0;
            r_memtoreg_m   <= 1'b0;
            r_memwrite_m   <= 1'b0;
            r_alu_result_m <= '0;
            r_write_data_m <= '0;
            r_wa3_m        <= 4'd0;
        end else if (FlushM) begin
            r_pcsrc_m      <= 1'b0;
            r_regwrite_m   <= 1'b0;
            r_memtoreg_m   <= 1'b0;
            r_memwrite_m   <= 1'b0;
            r_alu_result_m <= '0;
            r_write_data_m <= '0;
            r_wa3_m        <= 4'd0;
        end else if (!StallM) begin
            r_pcsrc_m      <= PCSrcE & w_cond_ex;
            r_regwrite_m   <= RegWriteE & w_cond_ex;
            r_memtoreg_m   <= MemtoRegE;
            r_memwrite_m   <= MemWriteE & w_cond_ex;
            r_alu_result_m <= ALUResultE;
            r_write_data_m <= WriteDataE;
            r_wa3_m        <= WA3E;
        end
    end

    assign Flags      = r_flags;
    assign PCSrcM     = r_pcsrc_m;
    assign RegWriteM  = r_regwrite_m;
    assign MemtoRegM  = r_memtoreg_m;
    assign MemWriteM  = r_memwrite_m;
    assign ALUResultM = r_alu_result_m;
    assign WriteDataM = r_write_data_m;
    assign WA3M       = r_wa3_m;

endmodule

// File: doc/cond_exec_mreg.md
Name: cond_exec_mreg

Overview:
- Execute-stage consumer of the decode/execute pipeline register in the pipelined ARM core.
- Evaluates the ARM condition field of the instruction in E against the architectural NZCV flags register, which this block owns.
- Gates the instruction's side effects (register write, memory write, PC redirect, flag write) on that result.
- Registers the surviving controls and datapath values into the memory-stage pipeline register, with stall and flush support driven by the hazard unit.

Parameters:
- WIDTH, 32, datapath width of ALUResult/WriteData.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; forces all state to zero immediately while low.
- PCSrcE  in  1  instruction in E writes the PC.
- RegWriteE  in  1  instruction in E writes the register file.
- MemtoRegE  in  1  writeback selects memory data.
- MemWriteE  in  1  instruction in E stores to memory.
- FlagWriteE  in  2  [1] updates N,Z; [0] updates C,V.
- CondE  in  4  ARM condition field.
- ALUFlags  in  4  NZCV produced by the ALU this cycle ({N,Z,C,V}, bit 3 = N).
- ALUResultE  in  WIDTH  ALU result.
- WriteDataE  in  WIDTH  store data.
- WA3E  in  4  destination register index.
- StallM  in  1  hold the M register and the flags.
- FlushM  in  1  insert a bubble into M.
- CondExE  out  1  combinational condition-pass for the instruction in E.
- BranchTakenE  out  1  combinational, PCSrcE & CondExE; feeds the hazard unit.
- Flags  out  4  current registered NZCV.
- PCSrcM, RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered, gated controls.
- ALUResultM, WriteDataM  out  WIDTH  registered data.
- WA3M  out  4  registered destination.

Behaviour:
- Reset (reset = 0, asynchronous): Flags = 0000; all M outputs = 0. Takes effect mid-cycle regardless of stall/flush. The first rising edge after release behaves normally.
- Condition decode uses the registered Flags (pre-update value), never ALUFlags:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C & ~Z
  - 1001 LS: ~C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: ~Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 0 (treated as never-execute)
- Flag update on the rising edge:
  - Flags[3:2] <= ALUFlags[3:2] when FlagWriteE[1] & CondExE & ~StallM & ~FlushM.
  - Flags[1:0] <= ALUFlags[1:0] when FlagWriteE[0] & CondExE & ~StallM & ~FlushM.
  - Otherwise hold. The two halves update independently.
- M register priority on each rising edge: reset > FlushM > StallM > load.
  - FlushM = 1: all M controls and data <= 0, even when StallM = 1.
  - StallM = 1 (no flush): all M outputs hold.
  - Load: PCSrcM <= PCSrcE & CondExE; RegWriteM <= RegWriteE & CondExE; MemWriteM <= MemWriteE & CondExE. MemtoRegM, ALUResultM, WriteDataM and WA3M load ungated.
- Latency: inputs in E appear on M outputs exactly one cycle later. CondExE and BranchTakenE have zero latency.
- Back-to-back flag setting: instruction k sets flags at edge t. Instruction k+1, in E during the following cycle, sees the new flags. No internal bypass from ALUFlags.
- A failed condition produces a valid M entry with all side-effect controls cleared. It is not a flush; data fields still load.

Test Plan:
- Reset: drive inputs nonzero, pull reset low mid-cycle -> Flags = 0000 and every M output = 0 immediately, with no clock edge needed. Release, one edge with CondE = 1110, RegWriteE = 1, WA3E = 5, ALUResultE = 0x0000_00AA -> RegWriteM = 1, WA3M = 5, ALUResultM = 0xAA.
- Condition sweep: preload Flags to each of the 16 NZCV values via FlagWriteE = 11, CondE = 1110. For every CondE 0000..1111, check CondExE against the table. Example: Flags = 1001 (N = 1, V = 1) with GE -> 1, LT -> 0, GT -> 1; CondE = 1111 -> 0.
- Gating: Flags = 0000, CondE = 0000 (EQ), RegWriteE = MemWriteE = PCSrcE = 1 -> next edge RegWriteM = MemWriteM = PCSrcM = 0, WA3M/ALUResultM still loaded, BranchTakenE = 0.
- Split flag write: Flags = 0000, FlagWriteE = 10, ALUFlags = 1111, CondE = AL -> Flags = 1100. Then FlagWriteE = 01, ALUFlags = 0011 -> Flags = 1111. A failed-condition instruction with FlagWriteE = 11 -> Flags unchanged.
- Stall: load the M register, then hold StallM = 1 for 3 cycles while changing all E inputs and setting FlagWriteE = 11 with ALUFlags = 0100 -> M outputs and Flags unchanged for all 3 cycles. On release the next edge loads the current E values.
- Flush priority: StallM = 1 and FlushM = 1 together with FlagWriteE = 11, CondE = AL -> all M outputs 0 after the edge, Flags unchanged.
